// File: rtl/airi5c_post_normalizer_if.sv
// airi5c_post_normalizer_if: operand/result valid-ready bundle of the FPU post-normalizer
interface airi5c_post_normalizer_if;
   logic        in_valid;
   logic        in_ready;
   logic        sign_in;
   logic [9:0]  exp_in;
   logic [27:0] man_in;
   logic [2:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  flags;
   modport master (output in_valid, sign_in, exp_in, man_in, rm, out_ready,
                   input  in_ready, out_valid, result, flags);
   modport slave  (input  in_valid, sign_in, exp_in, man_in, rm, out_ready,
                   output in_ready, out_valid, result, flags);
endinterface

// File: rtl/airi5c_post_normalizer.sv
// airi5c_post_normalizer: packs a raw binary32 result into IEEE-754 plus flags; AIRI5C_FPU_FTZ_EN flushes tiny results to zero
module airi5c_post_normalizer (
   input  logic clk,
   input  logic reset,
   input  logic kill,
   airi5c_post_normalizer_if.slave b
);
   typedef enum logic [2:0] {IDLE, NORM, DENORM, ROUND, DONE} state_t;
   localparam logic [2:0] RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
   state_t st;
   logic s, z, t, inex, inc, ovf, to_inf;
   logic [2:0] r;
   logic signed [9:0] e, e_sat;
   logic signed [10:0] e_sum, eb, sh;
   logic [9:0] be;
   logic [27:0] m, m_n, m_d;
   logic [4:0] lzc, flg_n;
   logic [32:0] w;
   logic [31:0] res_n;
   // leading-zero count of the integer+fraction field (bit 26 down to 0)
   always_comb begin
      lzc = 5'd0;
      for (int i = 0; i < 27; i++) if (m[i]) lzc = 5'(26 - i);
   end
   // normalize: a carry shifts right keeping sticky, otherwise shift left by lzc; exponent saturates at +-511
   always_comb begin
      e_sum = m[27] ? {e[9], e} + 11'sd1 : {e[9], e} - {6'd0, lzc};
      e_sat = e_sum > 11'sd511 ? 10'sd511 : e_sum < -11'sd511 ? -10'sd511 : e_sum[9:0];
      m_n = m[27] ? {1'b0, m[27:2], m[1] | m[0]} : m << lzc;
   end
   // denormalize: non-positive biased exponent shifts right by 1-e, folding lost bits into sticky
   always_comb begin
      eb = {e[9], e} + 11'sd127;
      sh = 11'sd1 - eb;
      m_d = (m >> sh) | {27'd0, |(m & ~({28{1'b1}} << sh))};
   end
   // round and pack; a fraction carry ripples straight into the exponent field
   always_comb begin
      inex = |m[2:0];
      inc = r == RTZ ? 1'b0 : r == RDN ? inex & s : r == RUP ? inex & ~s : r == RMM ? m[2] : m[2] & (m[3] | m[1] | m[0]);
      w = {be, m[25:3]} + {32'd0, inc};
      ovf = w[32:23] >= 10'd255;
      to_inf = r == RUP ? ~s : r == RDN ? s : r != RTZ;
      res_n = ovf ? {s, to_inf ? 31'h7F800000 : 31'h7F7FFFFF} : {s, w[30:0]};
      flg_n = {2'b00, ovf, t & inex, inex | ovf};
   end
   // control FSM, one datapath step per state, handshake outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         st <= IDLE;
         b.in_ready <= 1'b1;
         b.out_valid <= 1'b0;
         b.result <= 32'd0;
         b.flags <= 5'd0;
      end else if (kill) begin
         st <= IDLE;
         b.in_ready <= 1'b1;
         b.out_valid <= 1'b0;
      end else begin
         case (st)
            IDLE: if (b.in_valid) begin
               st <= NORM;
               b.in_ready <= 1'b0;
               s <= b.sign_in;
               e <= b.exp_in;
               m <= b.man_in;
               r <= b.rm > 3'd4 ? 3'd0 : b.rm;
            end
            NORM: begin
               st <= DENORM;
               z <= m == 28'd0;
               m <= m_n;
               e <= e_sat;
            end
            DENORM: begin
               st <= ROUND;
               t <= eb < 11'sd1;
               be <= eb < 11'sd1 ? 10'd0 : eb[9:0];
`ifndef AIRI5C_FPU_FTZ_EN
               m <= eb < 11'sd1 ? m_d : m;
`endif
            end
            ROUND: begin
               st <= DONE;
               b.out_valid <= 1'b1;
`ifdef AIRI5C_FPU_FTZ_EN
               b.result <= z | t ? {s, 31'd0} : res_n;
               b.flags <= z ? 5'd0 : t ? 5'b00011 : flg_n;
`else
               b.result <= z ? {s, 31'd0} : res_n;
               b.flags <= z ? 5'd0 : flg_n;
`endif
            end
            DONE: if (b.out_ready) begin
               st <= IDLE;
               b.out_valid <= 1'b0;
               b.in_ready <= 1'b1;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_airi5c_post_normalizer.sv
// tb_airi5c_post_normalizer: vector table, handshake corner sequences and random ops against an exact-value model
module tb_airi5c_post_normalizer;
   logic clk = 1'b0, reset = 1'b1, kill = 1'b0;
   int total = 0, bad = 0;
   airi5c_post_normalizer_if bus();
   airi5c_post_normalizer dut (.clk(clk), .reset(reset), .kill(kill), .b(bus.slave));
   always #5 clk = ~clk;

   typedef struct {
      logic sg; logic [9:0] ex; logic [27:0] mn; logic [2:0] rm; logic [31:0] res; logic [4:0] fl;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic add(input logic sg, input logic [9:0] ex, input logic [27:0] mn, input logic [2:0] rm,
                      input logic [31:0] res, input logic [4:0] fl);
      vec_t v;
      v.sg = sg; v.ex = ex; v.mn = mn; v.rm = rm; v.res = res; v.fl = fl;
      tbl.push_back(v);
   endtask

   // value = mn * 2^(ex-26); rounded exactly to the binary32 grid using integer arithmetic
   function automatic void model(input logic sg, input logic [9:0] ex, input logic [27:0] mn, input logic [2:0] rmode,
                                 output logic [31:0] res, output logic [4:0] fl);
      int x, p, et, q, d, rr;
      longint n, rem, half;
      logic inex, up, tiny, ovf, inf;
      x = int'($signed(ex));
      rr = rmode > 3'd4 ? 0 : int'(rmode);
      if (mn == 28'd0) begin
         res = {sg, 31'd0}; fl = 5'd0;
         return;
      end
      p = 27;
      while (!mn[p]) p--;
      et = x - 26 + p;
      tiny = et < -126;
`ifdef AIRI5C_FPU_FTZ_EN
      if (tiny) begin
         res = {sg, 31'd0}; fl = 5'b00011;
         return;
      end
`endif
      q = (tiny ? -126 : et) - 23;
      d = q - (x - 26);
      if (d <= 0) begin n = longint'(mn) << (-d); rem = 0; half = 1; end
      else if (d > 40) begin n = 0; rem = 1; half = 2; end
      else begin
         n = longint'(mn) >> d;
         rem = longint'(mn) & ((64'sd1 << d) - 1);
         half = 64'sd1 << (d - 1);
      end
      inex = rem != 0;
      case (rr)
         0: up = (rem > half) || (rem == half && n[0]);
         1: up = 1'b0;
         2: up = inex & sg;
         3: up = inex & ~sg;
         default: up = rem >= half;
      endcase
      n += longint'(up);
      if (n == (64'sd1 << 24)) begin n = n >> 1; q++; end
      ovf = (n >= (64'sd1 << 23)) && (q + 150 >= 255);
      if (ovf) begin
         inf = rr == 3 ? ~sg : rr == 2 ? sg : rr != 1;
         res = {sg, inf ? 31'h7F800000 : 31'h7F7FFFFF};
      end else res = {sg, n >= (64'sd1 << 23) ? 8'(q + 150) : 8'd0, n[22:0]};
      fl = {2'b00, ovf, tiny & inex, inex | ovf};
   endfunction

   // one operation: accept, measure latency (counting the accept edge), optionally stall, then pop
   task automatic op(input logic sg, input logic [9:0] ex, input logic [27:0] mn, input logic [2:0] rmode,
                     input int stall, output logic [31:0] res, output logic [4:0] fl);
      int n;
      n = 0;
      while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
      chk("in_ready_before_op", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1; bus.sign_in = sg; bus.exp_in = ex; bus.man_in = mn; bus.rm = rmode; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
      chk("latency", n, 32'd4);
      repeat (stall) @(negedge clk);
      res = bus.result; fl = bus.flags;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] r, er, prev_r;
      logic [4:0] f, ef, prev_f;
      logic sg;
      logic [9:0] ex;
      logic [27:0] mn;
      logic [2:0] rmode;
      int n, hi, xi;
      bus.in_valid = 1'b0; bus.sign_in = 1'b0; bus.exp_in = '0; bus.man_in = '0; bus.rm = '0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_flags", {27'd0, bus.flags}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      add(1'b0, 10'h000, 28'h4000000, 3'd0, 32'h3F800000, 5'h00);
      add(1'b0, 10'h000, 28'hC000000, 3'd0, 32'h40400000, 5'h00);
      add(1'b0, 10'h000, 28'h400000C, 3'd0, 32'h3F800002, 5'h01);
      add(1'b0, 10'h000, 28'h4000004, 3'd0, 32'h3F800000, 5'h01);
      add(1'b0, 10'h080, 28'h4000000, 3'd0, 32'h7F800000, 5'h05);
      add(1'b0, 10'h080, 28'h4000000, 3'd1, 32'h7F7FFFFF, 5'h05);
      add(1'b1, 10'h080, 28'h4000000, 3'd3, 32'hFF7FFFFF, 5'h05);
      add(1'b1, 10'h000, 28'h0000000, 3'd0, 32'h80000000, 5'h00);
      add(1'b0, 10'h000, 28'h4000004, 3'd4, 32'h3F800001, 5'h01);
      add(1'b1, 10'h000, 28'h4000001, 3'd2, 32'hBF800001, 5'h01);
      add(1'b0, 10'h000, 28'h400000C, 3'd7, 32'h3F800002, 5'h01);
      add(1'b0, 10'h01A, 28'h0000001, 3'd0, 32'h3F800000, 5'h00);
      add(1'b0, 10'h1FF, 28'hC000000, 3'd0, 32'h7F800000, 5'h05);
`ifdef AIRI5C_FPU_FTZ_EN
      add(1'b0, 10'h381, 28'h4000000, 3'd0, 32'h00000000, 5'h03);
      add(1'b0, 10'h381, 28'h4000001, 3'd3, 32'h00000000, 5'h03);
      add(1'b0, 10'h381, 28'h7FFFFFF, 3'd0, 32'h00000000, 5'h03);
`else
      add(1'b0, 10'h381, 28'h4000000, 3'd0, 32'h00400000, 5'h00);
      add(1'b0, 10'h381, 28'h4000001, 3'd3, 32'h00400001, 5'h03);
      add(1'b0, 10'h381, 28'h7FFFFFF, 3'd0, 32'h00800000, 5'h03);
`endif
      foreach (tbl[i]) begin
         op(tbl[i].sg, tbl[i].ex, tbl[i].mn, tbl[i].rm, 0, r, f);
         chk($sformatf("vec%0d_result", i), r, tbl[i].res);
         chk($sformatf("vec%0d_flags", i), {27'd0, f}, {27'd0, tbl[i].fl});
      end

      // stall: result, flags and in_ready hold while out_ready stays low; no accept in the DONE cycle
      bus.in_valid = 1'b1; bus.sign_in = 1'b0; bus.exp_in = 10'h000; bus.man_in = 28'h400000C; bus.rm = 3'd0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
      chk("stall_valid_rise", {31'd0, bus.out_valid}, 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("stall_result", bus.result, 32'h3F800002);
         chk("stall_flags", {27'd0, bus.flags}, 32'h1);
         chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      end
      bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b0;
      chk("done_no_accept_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("done_out_valid_drop", {31'd0, bus.out_valid}, 32'd0);

      // kill in NORM: never completes, in_ready back next cycle, result/flags untouched
      prev_r = bus.result; prev_f = bus.flags;
      bus.in_valid = 1'b1; bus.exp_in = 10'h001; bus.man_in = 28'h4000000;
      @(negedge clk);
      bus.in_valid = 1'b0; kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_in_ready", {31'd0, bus.in_ready}, 32'd1);
      hi = 0;
      for (int k = 0; k < 8; k++) begin @(negedge clk); hi += int'(bus.out_valid); end
      chk("kill_out_valid_never", hi, 32'd0);
      chk("kill_result_kept", bus.result, prev_r);
      chk("kill_flags_kept", {27'd0, bus.flags}, {27'd0, prev_f});
      // kill wins over in_valid in IDLE
      bus.in_valid = 1'b1; kill = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0; kill = 1'b0;
      chk("kill_over_in_valid", {31'd0, bus.in_ready}, 32'd1);

      // reset while in ROUND
      op(1'b0, 10'h000, 28'h400000C, 3'd0, 0, r, f);
      bus.in_valid = 1'b1; bus.exp_in = 10'h001; bus.man_in = 28'h4000000;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_round_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_round_result", bus.result, 32'd0);
      chk("rst_round_flags", {27'd0, bus.flags}, 32'd0);
      chk("rst_round_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // randomized operations against the exact-value model
      for (int k = 0; k < 300; k++) begin
         sg = 1'($urandom);
         rmode = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: ex = 10'($urandom);
            1: begin xi = int'($urandom_range(0, 50)) - 150; ex = 10'(xi); end
            2: begin xi = int'($urandom_range(0, 40)) - 20; ex = 10'(xi); end
            default: begin xi = int'($urandom_range(100, 130)); ex = 10'(xi); end
         endcase
         case ($urandom_range(0, 7))
            0: mn = 28'd0;
            1, 2: mn = 28'($urandom);
            3, 4: mn = {2'b01, 26'($urandom)};
            default: mn = 28'($urandom) >> $urandom_range(0, 27);
         endcase
         op(sg, ex, mn, rmode, int'($urandom_range(0, 3)), r, f);
         model(sg, ex, mn, rmode, er, ef);
         chk("rnd_result", r, er);
         chk("rnd_flags", {27'd0, f}, {27'd0, ef});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
